// File: rtl/tempsense_pkg.sv
// Shared constants for the temperature-sensor capture block: register map,
// STATUS/CTRL bit positions, sample width and the bus-handshake state type.
package tempsense_pkg;

    localparam int SAMPLE_W = 24;

    // Register offsets, selected by wbs_adr_i[3:2]
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS bit positions (count occupies [7:0])
    localparam int ST_EMPTY = 8;
    localparam int ST_FULL  = 9;
    localparam int ST_OVF   = 10;
    localparam int ST_EN    = 16;

    // CTRL bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/tempsense_capture_if.sv
// Wishbone classic slave bus bundle used between the management SoC and
// the sensor capture block.
interface tempsense_capture_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/tempsense_fifo.sv
// Small show-ahead sample FIFO. A pop frees a slot in the same cycle, so a
// push into a full FIFO alongside a pop is accepted. Flush beats push.
module tempsense_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [W-1:0]                 i_din,
    output logic [W-1:0]                 o_dout,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop, w_do_push;

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | (i_pop & ~o_empty)) & ~i_flush;
    // A dropped sample is one refused for lack of space, not one discarded by flush
    assign o_drop    = i_push & o_full & ~(i_pop & ~o_empty) & ~i_flush;

    // Sample storage; contents need no reset since count guards reads
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end
endmodule

// File: rtl/tempsense_capture.sv
// Captures sensor results on each synchronised DONE rise into a FIFO and
// exposes status/control/pop through a single-cycle-ack Wishbone slave.
module tempsense_capture
    import tempsense_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    tempsense_capture_if.slave  wb,
    input  logic                DONE,
    input  logic [SAMPLE_W-1:0] DOUT,
    output logic                irq_o
);
    localparam int CW = $clog2(DEPTH+1);

    logic                r_s1, r_s2, r_s3;
    logic                r_en, r_ovf, r_irq;
    logic [31:0]         r_dat;
    wb_state_e           r_state, w_state_nxt;
    logic                w_edge, w_push, w_hit, w_req, w_rd;
    logic                w_ctrl_wr, w_flush, w_pop, w_drop;
    logic [1:0]          w_reg;
    logic [31:0]         w_rdata;
    logic [SAMPLE_W-1:0] w_fifo_dout;
    logic [CW-1:0]       w_count;
    logic                w_empty, w_full;
    logic                w_unused;

    assign w_edge    = r_s2 & ~r_s3;
    assign w_push    = w_edge & r_en;
    assign w_hit     = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_req     = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o & w_hit;
    assign w_reg     = wb.wbs_adr_i[3:2];
    assign w_rd      = w_req & ~wb.wbs_we_i;
    assign w_ctrl_wr = w_req & wb.wbs_we_i & (w_reg == REG_CTRL) & wb.wbs_sel_i[0];
    assign w_flush   = w_ctrl_wr & wb.wbs_dat_i[CTRL_FLUSH];
    assign w_pop     = w_rd & (w_reg == REG_DATA) & ~w_empty;

    assign wb.wbs_ack_o = (r_state == WB_ACK);
    assign wb.wbs_dat_o = r_dat;
    assign irq_o        = r_irq;
    assign w_unused     = &{1'b0, wb.wbs_dat_i[31:2], wb.wbs_sel_i[3:1], wb.wbs_adr_i[1:0]};

    tempsense_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (DOUT),
        .o_dout  (w_fifo_dout),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    // DONE synchroniser plus history flop; history follows s2 regardless of en
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= DONE;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Read-data mux; an empty DATA read returns zero
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_STATUS: begin
                w_rdata[7:0]    = 8'(w_count);
                w_rdata[ST_EMPTY] = w_empty;
                w_rdata[ST_FULL]  = w_full;
                w_rdata[ST_OVF]   = r_ovf;
                w_rdata[ST_EN]    = r_en;
            end
            REG_DATA: if (!w_empty) w_rdata = {1'b1, 7'h0, w_fifo_dout};
            REG_CTRL:   w_rdata[CTRL_EN] = r_en;
            default:    w_rdata = '0;
        endcase
    end

    // Bus handshake state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= WB_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Bus handshake next state: one ack cycle per request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_IDLE: if (w_req) w_state_nxt = WB_ACK;
            WB_ACK:  w_state_nxt = WB_IDLE;
            default: w_state_nxt = WB_IDLE;
        endcase
    end

    // Control/status state: read data only lives in the ack cycle, overflow is sticky
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_dat <= '0;
            r_en  <= 1'b0;
            r_ovf <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_dat <= w_rd ? w_rdata : 32'h0;
            if (w_ctrl_wr) r_en <= wb.wbs_dat_i[CTRL_EN];
            if (w_flush)     r_ovf <= 1'b0;
            else if (w_drop) r_ovf <= 1'b1;
            r_irq <= r_en & ~w_empty;
        end
    end
endmodule

// File: tb/tb_tempsense_capture.sv
// Bench for tempsense_capture: register-map vector table, hand-timed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_tempsense_capture;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int OP_RD = 0, OP_WR = 1, OP_DN = 2;

    typedef struct {
        int          op;
        logic [1:0]  off;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        exp_irq;
        string       name;
    } vec_t;

    logic        clk, rst, done, irq;
    logic [23:0] dout;
    int          n_pass, n_tot;
    vec_t        tbl[$];

    // reference model state
    logic [23:0] m_q[$];
    logic        m_en, m_ovf;

    tempsense_capture_if bus();

    tempsense_capture #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus),
        .DONE     (done),
        .DOUT     (dout),
        .irq_o    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input int op, input logic [1:0] off, input logic [31:0] wd,
                       input logic [31:0] exp, input logic exp_irq, input string name);
        vec_t v;
        v.op = op; v.off = off; v.wd = wd; v.exp = exp; v.exp_irq = exp_irq; v.name = name;
        tbl.push_back(v);
    endtask

    // One Wishbone transfer starting just after the next rising edge
    task automatic wb_xfer(input logic we, input logic [1:0] off, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rd);
        int n;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = BASE | {28'h0, off, 2'b00};
        bus.wbs_dat_i = wd; bus.wbs_sel_i = sel;
        n = 0; rd = '0;
        do begin @(posedge clk); #1; n++; end while (!bus.wbs_ack_o && n < 8);
        check("wb_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
        rd = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic pulse_done(input logic [23:0] d);
        @(posedge clk); #3;
        dout = d; done = 1'b1;
        repeat (4) @(posedge clk);
        #3 done = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[7:0] = 8'(m_q.size());
        s[8]   = (m_q.size() == 0);
        s[9]   = (m_q.size() == DEPTH);
        s[10]  = m_ovf;
        s[16]  = m_en;
        return s;
    endfunction

    initial begin
        logic [31:0] rd;
        int lat, acks;
        logic [3:0] pat;
        n_pass = 0; n_tot = 0;
        rst = 1'b1; done = 1'b0; dout = '0;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        check("reset_dat", bus.wbs_dat_o, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);

        // ---- vector table ----
        add(OP_RD, 0, 0, 32'h0000_0100, 0, "status_reset");
        add(OP_WR, 2, 1, 0, 0, "ctrl_en");
        add(OP_DN, 0, 32'hABCDEF, 0, 1, "done_abcdef");
        add(OP_RD, 1, 0, 32'h80AB_CDEF, 0, "data_abcdef");
        add(OP_RD, 0, 0, 32'h0001_0100, 0, "status_after_pop");
        for (int i = 1; i <= 5; i++) add(OP_DN, 0, 32'(i), 0, 1, "done_n");
        add(OP_RD, 0, 0, 32'h0001_0604, 1, "status_full_ovf");
        for (int i = 1; i <= 4; i++) add(OP_RD, 1, 0, 32'h8000_0000 | 32'(i), i < 4, "data_n");
        add(OP_RD, 1, 0, 32'h0, 0, "data_empty");
        add(OP_RD, 0, 0, 32'h0001_0500, 0, "status_ovf_sticky");
        add(OP_WR, 2, 3, 0, 0, "ctrl_flush");
        add(OP_RD, 0, 0, 32'h0001_0100, 0, "status_flushed");
        add(OP_RD, 2, 0, 32'h1, 0, "ctrl_read");
        add(OP_RD, 3, 0, 32'h0, 0, "reg3_read");
        add(OP_WR, 0, 32'hFFFF_FFFF, 0, 0, "status_wr");
        add(OP_WR, 3, 32'hFFFF_FFFF, 0, 0, "reg3_wr");
        add(OP_WR, 1, 32'hFFFF_FFFF, 0, 0, "data_wr");
        add(OP_RD, 0, 0, 32'h0001_0100, 0, "status_unchanged");
        foreach (tbl[k]) begin
            case (tbl[k].op)
                OP_RD: begin
                    wb_xfer(1'b0, tbl[k].off, 0, 4'hF, rd);
                    check(tbl[k].name, rd, tbl[k].exp);
                end
                OP_WR:   wb_xfer(1'b1, tbl[k].off, tbl[k].wd, 4'hF, rd);
                default: pulse_done(tbl[k].wd[23:0]);
            endcase
            repeat (2) @(posedge clk); #1;
            check({tbl[k].name, "_irq"}, {31'h0, irq}, {31'h0, tbl[k].exp_irq});
        end

        // ---- irq latency from DONE rise (en=1, empty) ----
        @(posedge clk); #3;
        dout = 24'h123456; done = 1'b1; lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (irq && lat == 0) lat = n;
        end
        done = 1'b0;
        check("irq_latency", 32'(lat), 32'd4);
        repeat (4) @(posedge clk);
        wb_xfer(1'b0, 1, 0, 4'hF, rd);
        check("data_123456", rd, 32'h8012_3456);

        // ---- back-to-back: strobe held gives ack every other cycle ----
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = BASE;
        for (int n = 0; n < 4; n++) begin @(posedge clk); #1; pat[n] = bus.wbs_ack_o; end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        check("b2b_ack_pattern", {28'h0, pat}, 32'h5);

        // ---- full FIFO: pop coincides with push edge ----
        for (int i = 5; i <= 8; i++) pulse_done(24'(i));
        wb_xfer(1'b0, 0, 0, 4'hF, rd);
        check("status_full", rd, 32'h0001_0204);
        @(posedge clk); #3;
        dout = 24'h9; done = 1'b1;
        @(posedge clk);
        wb_xfer(1'b0, 1, 0, 4'hF, rd);   // request sampled on the push-edge cycle
        done = 1'b0;
        check("pop_push_data", rd, 32'h8000_0005);
        wb_xfer(1'b0, 0, 0, 4'hF, rd);
        check("pop_push_status", rd, 32'h0001_0204);
        for (int i = 6; i <= 9; i++) begin
            wb_xfer(1'b0, 1, 0, 4'hF, rd);
            check("drain", rd, 32'h8000_0000 | 32'(i));
        end
        wb_xfer(1'b0, 1, 0, 4'hF, rd);
        check("drain_empty", rd, 32'h0);

        // ---- flush coincides with push edge ----
        pulse_done(24'h11);
        pulse_done(24'h22);
        @(posedge clk); #3;
        dout = 24'h33; done = 1'b1;
        @(posedge clk);
        wb_xfer(1'b1, 2, 32'h3, 4'h1, rd);
        done = 1'b0;
        wb_xfer(1'b0, 0, 0, 4'hF, rd);
        check("flush_push_status", rd, 32'h0001_0100);
        repeat (3) @(posedge clk); #1;
        check("flush_irq", {31'h0, irq}, 32'h0);

        // ---- address miss: no ack ----
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_adr_i = BASE + 32'h10;
        acks = 0;
        repeat (4) begin @(posedge clk); #1; acks += int'(bus.wbs_ack_o); end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        check("miss_no_ack", 32'(acks), 32'h0);

        // ---- reset mid-read ----
        pulse_done(24'h44);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = BASE;
        #2 rst = 1'b1;
        acks = 0;
        repeat (3) begin @(posedge clk); #1; acks += int'(bus.wbs_ack_o); end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        rst = 1'b0;
        @(posedge clk); #1; acks += int'(bus.wbs_ack_o);
        check("rst_mid_ack", 32'(acks), 32'h0);
        pulse_done(24'h55);
        wb_xfer(1'b0, 0, 0, 4'hF, rd);
        check("rst_status", rd, 32'h0000_0100);
        check("rst_irq", {31'h0, irq}, 32'h0);

        // ---- randomized traffic vs reference model ----
        m_q.delete(); m_en = 1'b0; m_ovf = 1'b0;
        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                logic [23:0] d;
                d = 24'($urandom);
                pulse_done(d);
                if (m_en) begin
                    if (m_q.size() < DEPTH) m_q.push_back(d);
                    else m_ovf = 1'b1;
                end
            end else if (r <= 4) begin
                logic [31:0] e;
                e = '0;
                if (m_q.size() > 0) e = {8'h80, m_q.pop_front()};
                wb_xfer(1'b0, 1, 0, 4'hF, rd);
                check("rand_data", rd, e);
            end else if (r == 5) begin
                wb_xfer(1'b0, 0, 0, 4'hF, rd);
                check("rand_status", rd, exp_status());
            end else if (r == 6) begin
                logic [31:0] wd;
                logic [3:0]  sel;
                wd  = {$urandom} & 32'hFFFF_FFFC;
                wd[0] = ($urandom_range(0, 3) != 0);
                wd[1] = ($urandom_range(0, 5) == 0);
                sel = 4'($urandom);
                wb_xfer(1'b1, 2, wd, sel, rd);
                if (sel[0]) begin
                    m_en = wd[0];
                    if (wd[1]) begin m_q.delete(); m_ovf = 1'b0; end
                end
            end else if (r == 7) begin
                wb_xfer(1'b0, 2, 0, 4'hF, rd);
                check("rand_ctrl", rd, {31'h0, m_en});
            end else if (r == 8) begin
                logic [1:0] off;
                off = 2'($urandom_range(0, 2));
                if (off == 2'd2) off = 2'd3;
                wb_xfer(1'b1, off, $urandom, 4'hF, rd);
                wb_xfer(1'b0, 0, 0, 4'hF, rd);
                check("rand_wr_ignored", rd, exp_status());
            end else begin
                repeat (3) @(posedge clk); #1;
                check("rand_irq", {31'h0, irq}, {31'h0, (m_en && m_q.size() > 0)});
                check("rand_idle_dat", bus.wbs_dat_o, 32'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/tempsense_capture.md
# tempsense_capture

Downstream consumer of the temperature-sensor wrapper. Synchronises the sensor's asynchronous DONE strobe into the Wishbone clock domain, captures each 24-bit DOUT result into a small FIFO, and exposes status, control and sample pop through a Wishbone slave for the management SoC. An interrupt flags pending samples.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `BASE_ADDR`, 32'h3000_0000: slave base. Decode is `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset: asynchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle, strobe and write-enable.
- `wbs_sel_i`  in  4  byte lanes.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data.
- `DONE`  in  1  sensor conversion-done. Asynchronous to `wb_clk_i`; stays high at least 3 `wb_clk_i` cycles.
- `DOUT`  in  24  sensor result. Held stable from DONE rise until the next conversion starts.
- `irq_o`  out  1  high while `en` = 1 and the FIFO is non-empty.

## Operation
- **Registers** (`wbs_adr_i[3:2]`):
  - 0 `STATUS` (read-only): [7:0] count, [8] empty, [9] full, [10] overflow (sticky), [16] `en`.
  - 1 `DATA`:
    - Read when non-empty: {1'b1, 7'h0, sample[23:0]}, and the FIFO pops.
    - Read when empty: returns 0; no pop.
  - 2 `CTRL`:
    - Write with `wbs_sel_i[0]` set: bit0 → `en`; bit1 = 1 flushes the FIFO and clears overflow (self-clearing, reads 0).
    - Read: {31'h0, en}.
  - 3: reads 0.
  - Writes to `STATUS`, `DATA` and offset 3 are ignored but still acked.
- **DONE capture:**
  - DONE passes through a 2-flop synchroniser (`s1`, `s2`) plus a history flop `s3`.
  - Edge: `s2 & ~s3`.
  - On the edge cycle with `en` = 1, DOUT is pushed; DOUT has been stable ≥2 cycles by then.
  - With `en` = 0, the edge is ignored.
- **Full FIFO:** a push with no pop in the same cycle is dropped and sets overflow.
- **Simultaneous events:**
  - Pop + push on a full FIFO: both happen; count unchanged; no overflow.
  - Pop request on an empty FIFO + push: the read returns 0 and the push lands.
  - Flush + push: flush wins; the sample is dropped; overflow is not set.
- **Count:** width `$clog2(DEPTH+1)`, zero-extended into [7:0]. Pointers wrap modulo DEPTH.

## Timing
- **Request:** `wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & addr_hit`.
- **Ack:** `wbs_ack_o` is registered and asserts the cycle after the request, for exactly one cycle.
- **Read data:** `wbs_dat_o` is valid only while ack is high; 0 otherwise.
- **Back-to-back:** a strobe held through ack yields a new request on the cycle after ack.
- **Side-effect cycle:** pop, `CTRL` update and flush take effect on the request cycle, i.e. at the same clock edge that raises ack. `STATUS` read in the next transaction reflects them.
- **DONE latency:** DONE rise to push edge is 2–3 cycles (synchroniser). Count increments the following cycle; `irq_o` is registered, high one cycle after that.
- **Reset:** all outputs 0, FIFO empty, `en` = 0, overflow = 0, synchroniser flops 0.
  - Reset mid-transaction: ack is suppressed and the transaction is lost; the master must retry.
  - A DONE already high at reset release produces a capture edge only if `en` is later set and a fresh rise occurs. `s3` tracks `s2` even while `en` = 0.

## Structure
- Package `tempsense_pkg`: register offsets (`REG_STATUS`, `REG_DATA`, `REG_CTRL`), STATUS/CTRL bit-position constants, `SAMPLE_W` = 24.
- Sub-module `tempsense_fifo`:
  - Parameterised on DEPTH and width.
  - Ports: push/pop/flush, data in/out, count/empty/full, overflow-drop indication.
  - Implements the pop-before-push rule on full.
- Top level holds the synchroniser, edge detect, register decode and Wishbone FSM (IDLE → ACK → IDLE).

## Test plan
- Reset, then read `STATUS` → 0x0000_0100 (empty); `irq_o` = 0.
- Write `CTRL` = 1; pulse DONE with DOUT = 24'hABCDEF → within 4 cycles `irq_o` = 1; `DATA` read → 0x80AB_CDEF; next `STATUS` → 0x0001_0100.
- Five DONE pulses (DOUT 1..5) with DEPTH = 4 → `STATUS` = 0x0001_0604 (full + overflow); reads return 0x8000_0001..0x8000_0004, then 0.
- FIFO full; a `DATA` read ack coincides with the DONE edge for DOUT = 9 → no overflow; count stays 4; last pop after draining = 0x8000_0009.
- Write `CTRL` = 3 with 2 samples pending → `STATUS` = 0x0001_0100; a DONE edge on the same cycle as the flush is dropped.
- Assert `wb_rst_i` mid-read (stb held) → `wbs_ack_o` stays 0; after release `en` = 0 and a DONE pulse is not captured.
